// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver: N_DIGITS common digits, per-slot blank time,
// per-digit enable/blink, and display data swapped only at frame boundaries.
module seg7_scan_driver #(
   parameter int N_DIGITS     = 4,
   parameter int CLK_DIV      = 96,
   parameter int BLANK_CYCLES = 2,
   parameter int BLINK_FRAMES = 64,
   parameter bit SEG_ACT_LOW  = 1'b1,
   parameter bit DIG_ACT_LOW  = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*N_DIGITS-1:0]   digit_data,
   input  logic                    load,
   input  logic [N_DIGITS-1:0]     digit_en,
   input  logic [N_DIGITS-1:0]     blink_mask,
   output logic [6:0]              seg,
   output logic [N_DIGITS-1:0]     dig,
   output logic                    frame_tick
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

   // Active-high {G,F,E,D,C,B,A}; polarity is applied at the output register.
   function automatic logic [6:0] decode7(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         4'd10:   s = 7'h3E;
         4'd11:   s = 7'h5E;
         4'd12:   s = 7'h73;
         4'd13:   s = 7'h40;
         4'd14:   s = 7'h79;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   logic [PW-1:0]               presc_q, presc_d;
   logic [IW-1:0]               idx_q, idx_d;
   state_t                      state_q, state_d;
   logic [FW-1:0]               frame_cnt_q, frame_cnt_d;
   logic                        blink_phase_q, blink_phase_d;
   logic [N_DIGITS-1:0][3:0]    pending_q, pending_d;
   logic                        pending_valid_q, pending_valid_d;
   logic [N_DIGITS-1:0][3:0]    shadow_q, shadow_d;
   logic [6:0]                  seg_q, seg_d;
   logic [N_DIGITS-1:0]         dig_q, dig_d;
   logic                        frame_tick_q, frame_tick_d;
   logic                        slot_end, frame_end, digit_on;

   // Slot prescaler and digit index
   always_comb begin
      slot_end  = (presc_q == PW'(CLK_DIV - 1));
      frame_end = slot_end && (idx_q == IW'(N_DIGITS - 1));
      presc_d   = slot_end ? '0 : presc_q + PW'(1);
      if (frame_end) begin
         idx_d = '0;
      end else if (slot_end) begin
         idx_d = idx_q + IW'(1);
      end else begin
         idx_d = idx_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: dark at the head of every slot
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BLANK: state_d = (presc_d >= PW'(BLANK_CYCLES)) ? ST_DRIVE : ST_BLANK;
         ST_DRIVE: state_d = slot_end ? ST_BLANK : ST_DRIVE;
         default:  state_d = ST_BLANK;
      endcase
   end

   // FSM outputs: select and segments for the current slot
   always_comb begin
      digit_on = (state_q == ST_DRIVE) && digit_en[idx_q] &&
                 !(blink_mask[idx_q] && blink_phase_q);
      seg_d = (digit_on ? decode7(shadow_q[idx_q]) : 7'h00) ^ {7{SEG_ACT_LOW}};
      for (int i = 0; i < N_DIGITS; i++) begin
         dig_d[i] = (digit_on && (idx_q == IW'(i))) ^ DIG_ACT_LOW;
      end
      frame_tick_d = frame_end;
   end

   // Double buffer and blink phase; shadow only moves at a frame boundary
   always_comb begin
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
      shadow_d        = shadow_q;
      frame_cnt_d     = frame_cnt_q;
      blink_phase_d   = blink_phase_q;
      if (frame_end) begin
         if (load) begin
            shadow_d = digit_data;
         end else if (pending_valid_q) begin
            shadow_d = pending_q;
         end else begin
            shadow_d = shadow_q;
         end
         pending_valid_d = 1'b0;
         if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
         end
      end else if (load) begin
         pending_d       = digit_data;
         pending_valid_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q         <= '0;
         idx_q           <= '0;
         frame_cnt_q     <= '0;
         blink_phase_q   <= 1'b0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         shadow_q        <= '1;
         seg_q           <= {7{SEG_ACT_LOW}};
         dig_q           <= {N_DIGITS{DIG_ACT_LOW}};
         frame_tick_q    <= 1'b0;
      end else begin
         presc_q         <= presc_d;
         idx_q           <= idx_d;
         frame_cnt_q     <= frame_cnt_d;
         blink_phase_q   <= blink_phase_d;
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
         shadow_q        <= shadow_d;
         seg_q           <= seg_d;
         dig_q           <= dig_d;
         frame_tick_q    <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dig        = dig_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-level reference model derived from elapsed cycle count,
// decode vector table, directed corner sequences and randomized enable/blink/load traffic.
module tb_seg7_scan_driver;
   localparam int ND    = 4;
   localparam int CD    = 8;
   localparam int BC    = 2;
   localparam int BF    = 2;
   localparam int FRAME = CD * ND;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digit_data = 16'h0000;
   logic [3:0]  digit_en = 4'b1111;
   logic [3:0]  blink_mask = 4'b0000;
   logic [6:0]  seg;
   logic [3:0]  dig;
   logic        frame_tick;

   seg7_scan_driver #(
      .N_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF),
      .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .digit_data(digit_data), .load(load),
      .digit_en(digit_en), .blink_mask(blink_mask),
      .seg(seg), .dig(dig), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] code;
      logic [6:0] exp_seg;
   } dec_vec_t;

   dec_vec_t   dec_tbl[16];
   logic [6:0] seg_ref[16];
   int         vectors = 0;
   int         miscompares = 0;

   int         n;
   logic [3:0] shadow_m[ND];
   logic [3:0] pend_m[ND];
   bit         pv_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, n, $time);
      end
   endtask

   task automatic model_reset();
      n = 0;
      pv_m = 1'b0;
      for (int i = 0; i < ND; i++) begin
         shadow_m[i] = 4'hF;
         pend_m[i]   = 4'h0;
      end
   endtask

   // One clock: predict the registered outputs from elapsed cycles, advance the model, compare.
   task automatic step();
      int         s, pos, slot, frame;
      bit         phase, lit, bnd;
      logic [6:0] es;
      logic [3:0] ed;
      s     = n;
      pos   = s % CD;
      slot  = (s / CD) % ND;
      frame = s / FRAME;
      phase = ((frame / BF) % 2) == 1;
      lit   = (pos >= BC) && (digit_en[slot] == 1'b1) && !((blink_mask[slot] == 1'b1) && phase);
      es    = lit ? seg_ref[shadow_m[slot]] : 7'h7F;
      ed    = lit ? (4'b0001 << slot) : 4'b0000;
      bnd   = (s % FRAME) == (FRAME - 1);
      if (bnd) begin
         if (load) begin
            for (int i = 0; i < ND; i++) shadow_m[i] = digit_data[4*i +: 4];
         end else if (pv_m) begin
            for (int i = 0; i < ND; i++) shadow_m[i] = pend_m[i];
         end
         pv_m = 1'b0;
      end else if (load) begin
         for (int i = 0; i < ND; i++) pend_m[i] = digit_data[4*i +: 4];
         pv_m = 1'b1;
      end
      n++;
      @(posedge clk);
      #1;
      chk("seg", 32'(seg), 32'(es));
      chk("dig", 32'(dig), 32'(ed));
      chk("frame_tick", 32'(frame_tick), 32'(bnd));
   endtask

   task automatic pulse_load(input logic [15:0] data);
      digit_data = data;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic run_to(input int target);
      for (int k = 0; k < FRAME && (n % FRAME) != target; k++) step();
   endtask

   task automatic run_until(input int cyc);
      for (int k = 0; k < 4 * FRAME * 4 && n < cyc; k++) step();
   endtask

   // Asynchronous assert off the clock edge, immediate check, release on a quiet point.
   task automatic do_reset();
      #2;
      reset = 1'b0;
      #1;
      chk("reset_seg", 32'(seg), 32'h7F);
      chk("reset_dig", 32'(dig), 32'h0);
      chk("reset_tick", 32'(frame_tick), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      int ticks;
      seg_ref[0]  = 7'b1000000; seg_ref[1]  = 7'b1111001; seg_ref[2]  = 7'b0100100;
      seg_ref[3]  = 7'b0110000; seg_ref[4]  = 7'b0011001; seg_ref[5]  = 7'b0010010;
      seg_ref[6]  = 7'b0000010; seg_ref[7]  = 7'b1111000; seg_ref[8]  = 7'b0000000;
      seg_ref[9]  = 7'b0010000; seg_ref[10] = 7'b1000001; seg_ref[11] = 7'b0100001;
      seg_ref[12] = 7'b0001100; seg_ref[13] = 7'b0111111; seg_ref[14] = 7'b0000110;
      seg_ref[15] = 7'b1111111;
      for (int i = 0; i < 16; i++) begin
         dec_tbl[i].code    = 4'(i);
         dec_tbl[i].exp_seg = seg_ref[i];
      end
      model_reset();

      // Reset state while held
      repeat (2) @(posedge clk);
      #1;
      chk("reset_seg", 32'(seg), 32'h7F);
      chk("reset_dig", 32'(dig), 32'h0);
      chk("reset_tick", 32'(frame_tick), 32'h0);
      reset = 1'b1;

      // Basic scan: pending data appears from the second frame
      pulse_load(16'h3210);
      run_until(35);
      chk("scan_dig0", 32'(dig), 32'h1);
      chk("scan_seg0", 32'(seg), 32'(7'b1000000));
      run_until(43);
      chk("scan_dig1", 32'(dig), 32'h2);
      chk("scan_seg1", 32'(seg), 32'(7'b1111001));
      run_until(70);

      // Reset in the middle of DRIVE, then at least two dark cycles
      run_to(36);
      run_to(4);
      do_reset();
      step();
      chk("post_reset_dark1", 32'(dig), 32'h0);
      step();
      chk("post_reset_dark2", 32'(dig), 32'h0);

      // Two loads inside one frame: last write wins, current frame untouched
      run_to(9);
      pulse_load(16'hCBA9);
      run_to(17);
      pulse_load(16'hDDDD);
      run_to(0);
      run_to(3);
      chk("last_load_wins", 32'(seg), 32'(7'b0111111));

      // Load on the boundary cycle goes straight to the next frame
      run_to(31);
      pulse_load(16'h5E87);
      run_to(3);
      chk("boundary_load_seg", 32'(seg), 32'(seg_ref[7]));
      chk("boundary_load_dig", 32'(dig), 32'h1);

      // Decode table
      for (int v = 0; v < 16; v++) begin
         pulse_load({4{dec_tbl[v].code}});
         run_to(0);
         run_to(3);
         chk("decode", 32'(seg), 32'(dec_tbl[v].exp_seg));
      end

      // Blink on digit 0: dark in frames 2,3
      do_reset();
      blink_mask = 4'b0001;
      pulse_load(16'h1111);
      run_until(35);
      chk("blink_lit_f1", 32'(dig), 32'h1);
      run_until(67);
      chk("blink_dark_f2", 32'(dig), 32'h0);
      run_until(131);
      chk("blink_lit_f4", 32'(dig), 32'h1);
      run_until(6 * FRAME);
      blink_mask = 4'b0000;

      // Disabled digits: never selected, frame period unchanged
      digit_en = 4'b0101;
      ticks = 0;
      for (int k = 0; k < 4 * FRAME; k++) begin
         step();
         chk("disabled_dig", 32'(dig & 4'b1010), 32'h0);
         if (frame_tick) ticks++;
      end
      chk("tick_count", 32'(ticks), 32'd4);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
         if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
         digit_data = 16'($urandom);
         load = ($urandom_range(0, 9) == 0);
         step();
         load = 1'b0;
         if (k == 1500) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
